// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter between NrHosts bus hosts and NrDevices address-decoded devices.
// One transaction per cycle; each response is returned to its host one cycle after the grant.
module bus_rr_arbiter #(
  parameter int unsigned NrHosts   = 3,
  parameter int unsigned NrDevices = 2,
  parameter int unsigned MaxWait   = 15
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NrHosts-1:0]      host_req_i,
  input  logic [NrHosts-1:0]      host_we_i,
  input  logic [NrHosts*4-1:0]    host_be_i,
  input  logic [NrHosts*32-1:0]   host_addr_i,
  input  logic [NrHosts*32-1:0]   host_wdata_i,
  output logic [NrHosts-1:0]      host_gnt_o,
  output logic [NrHosts-1:0]      host_rvalid_o,
  output logic [31:0]             host_rdata_o,
  output logic [NrHosts-1:0]      host_err_o,
  output logic [NrDevices-1:0]    device_req_o,
  output logic                    device_we_o,
  output logic [3:0]              device_be_o,
  output logic [31:0]             device_addr_o,
  output logic [31:0]             device_wdata_o,
  input  logic [NrDevices-1:0]    device_rvalid_i,
  input  logic [NrDevices*32-1:0] device_rdata_i,
  input  logic [NrDevices-1:0]    device_err_i,
  input  logic [NrDevices*32-1:0] cfg_addr_base_i,
  input  logic [NrDevices*32-1:0] cfg_addr_mask_i,
  output logic [NrHosts-1:0]      starve_o
);

  localparam int unsigned HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned CandW = HostW + 1;
  localparam int unsigned DevW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int unsigned CntW  = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;

  logic [HostW-1:0] last_q;
  logic             rsp_valid_q;
  logic [HostW-1:0] rsp_host_q;
  logic [DevW-1:0]  rsp_dev_q;
  logic             rsp_miss_q;
  logic [CntW-1:0]  cnt_q [NrHosts];
  logic [CntW-1:0]  cnt_d [NrHosts];
  logic [NrHosts-1:0] starve_q, starve_d;

  logic             gnt_valid;
  logic [HostW-1:0] gnt_idx;
  logic [CandW-1:0] cand;
  logic             dev_hit;
  logic [DevW-1:0]  dev_idx;

  // Responses are assumed to arrive one cycle after the request, so device valid is not needed.
  logic unused_rvalid;
  assign unused_rvalid = ^device_rvalid_i;

  // Search starts just after the last granted host and wraps around.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (!rst_i) begin
      for (int unsigned i = 1; i <= NrHosts; i++) begin
        cand = {1'b0, last_q} + CandW'(i);
        if (cand >= CandW'(NrHosts)) cand = cand - CandW'(NrHosts);
        if (!gnt_valid && host_req_i[cand[HostW-1:0]]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand[HostW-1:0];
        end
      end
    end
  end

  always_comb begin
    host_gnt_o     = '0;
    device_we_o    = 1'b0;
    device_be_o    = '0;
    device_addr_o  = '0;
    device_wdata_o = '0;
    for (int unsigned h = 0; h < NrHosts; h++) begin
      if (gnt_valid && (gnt_idx == HostW'(h))) begin
        host_gnt_o[h]  = 1'b1;
        device_we_o    = host_we_i[h];
        device_be_o    = host_be_i[4*h +: 4];
        device_addr_o  = host_addr_i[32*h +: 32];
        device_wdata_o = host_wdata_i[32*h +: 32];
      end
    end
  end

  // Lowest matching device index wins the decode.
  always_comb begin
    dev_hit      = 1'b0;
    dev_idx      = '0;
    device_req_o = '0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      if (!dev_hit &&
          ((device_addr_o & cfg_addr_mask_i[32*d +: 32]) == cfg_addr_base_i[32*d +: 32])) begin
        dev_hit = 1'b1;
        dev_idx = DevW'(d);
      end
    end
    for (int unsigned d = 0; d < NrDevices; d++) begin
      if (gnt_valid && dev_hit && (dev_idx == DevW'(d))) device_req_o[d] = 1'b1;
    end
  end

  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    if (rsp_valid_q && !rst_i) begin
      for (int unsigned h = 0; h < NrHosts; h++) begin
        if (rsp_host_q == HostW'(h)) begin
          host_rvalid_o[h] = 1'b1;
          if (rsp_miss_q) begin
            host_err_o[h] = 1'b1;
          end else begin
            for (int unsigned d = 0; d < NrDevices; d++) begin
              if (rsp_dev_q == DevW'(d)) begin
                host_rdata_o  = device_rdata_i[32*d +: 32];
                host_err_o[h] = device_err_i[d];
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int unsigned h = 0; h < NrHosts; h++) begin
      cnt_d[h] = cnt_q[h];
      if (!host_req_i[h] || host_gnt_o[h]) begin
        cnt_d[h] = '0;
      end else if (cnt_q[h] != CntW'(MaxWait)) begin
        cnt_d[h] = cnt_q[h] + CntW'(1);
      end
      starve_d[h] = starve_q[h] | (cnt_d[h] == CntW'(MaxWait));
    end
  end

  assign starve_o = starve_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q      <= HostW'(NrHosts - 1);
      rsp_valid_q <= 1'b0;
      rsp_host_q  <= '0;
      rsp_dev_q   <= '0;
      rsp_miss_q  <= 1'b0;
      cnt_q       <= '{default: '0};
      starve_q    <= '0;
    end else begin
      rsp_valid_q <= gnt_valid;
      if (gnt_valid) begin
        last_q     <= gnt_idx;
        rsp_host_q <= gnt_idx;
        rsp_dev_q  <= dev_idx;
        rsp_miss_q <= !dev_hit;
      end
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scenario bench for bus_rr_arbiter; responses are scoreboarded against an address-map model.
// A small MaxWait lets ordinary three-way round-robin contention reach the starve threshold.
module tb_bus_rr_arbiter;

  localparam int unsigned NH = 3;
  localparam int unsigned ND = 2;
  localparam int unsigned MW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NH-1:0]   host_req, host_we;
  logic [NH*4-1:0] host_be;
  logic [NH*32-1:0] host_addr, host_wdata;
  logic [NH-1:0]   host_gnt, host_rvalid, host_err, starve;
  logic [31:0]     host_rdata;
  logic [ND-1:0]   dev_req, dev_rvalid, dev_err;
  logic            dev_we;
  logic [3:0]      dev_be;
  logic [31:0]     dev_addr, dev_wdata;
  logic [ND*32-1:0] dev_rdata, cfg_base, cfg_mask;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned host;
    logic [31:0] rdata;
    logic        err;
    int unsigned due;
  } rsp_t;
  rsp_t sb[$];

  bus_rr_arbiter #(.NrHosts(NH), .NrDevices(ND), .MaxWait(MW)) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_we_i(host_we), .host_be_i(host_be),
    .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
    .host_err_o(host_err),
    .device_req_o(dev_req), .device_we_o(dev_we), .device_be_o(dev_be),
    .device_addr_o(dev_addr), .device_wdata_o(dev_wdata),
    .device_rvalid_i(dev_rvalid), .device_rdata_i(dev_rdata), .device_err_i(dev_err),
    .cfg_addr_base_i(cfg_base), .cfg_addr_mask_i(cfg_mask),
    .starve_o(starve)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) dev_rvalid <= dev_req;

  // Device 0 is RAM at 0x0000_xxxx, device 1 at 0x0001_xxxx always errors.
  function automatic logic [32:0] model_rsp(input logic [31:0] a);
    if ((a & 32'hFFFF_0000) == 32'h0000_0000) return {1'b0, 32'hDEAD_BEEF};
    if ((a & 32'hFFFF_0000) == 32'h0001_0000) return {1'b1, 32'h0BAD_F00D};
    return {1'b1, 32'h0};
  endfunction

  task automatic push_rsp(input int unsigned h, input logic [31:0] a);
    rsp_t r;
    logic [32:0] m;
    m = model_rsp(a);
    r.host = h;
    r.err = m[32];
    r.rdata = m[31:0];
    r.due = cyc + 1;
    sb.push_back(r);
  endtask

  always @(negedge clk) begin
    rsp_t e;
    logic [NH-1:0] oh;
    #1;
    if (cyc >= 2) begin
      if (host_rvalid !== '0) begin
        checks++;
        if (sb.size() == 0 || sb[0].due != cyc) begin
          errors++;
          $display("FAIL rsp_unexpected cycle %0d: rvalid %b, expected no response", cyc,
                   host_rvalid);
        end else begin
          e = sb.pop_front();
          oh = NH'(1) << e.host;
          if (host_rvalid !== oh || host_rdata !== e.rdata || host_err !== (e.err ? oh : '0)) begin
            errors++;
            $display("FAIL rsp_data cycle %0d: rvalid %b rdata %h err %b, expected %b %h %b",
                     cyc, host_rvalid, host_rdata, host_err, oh, e.rdata, e.err ? oh : '0);
          end
        end
      end else begin
        checks++;
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          errors++;
          $display("FAIL rsp_missing cycle %0d: rvalid %b, expected host %0d", cyc,
                   host_rvalid, sb[0].host);
          void'(sb.pop_front());
        end else if (host_rdata !== 32'h0 || host_err !== '0) begin
          errors++;
          $display("FAIL rsp_idle cycle %0d: rdata %h err %b, expected 0 0", cyc, host_rdata,
                   host_err);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    host_req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    host_req = 3'b111;
    #1;
    checks++;
    if (host_gnt !== '0 || dev_req !== '0) begin
      errors++;
      $display("FAIL reset_gnt: gnt %b dreq %b, expected 000 00", host_gnt, dev_req);
    end
    tick();
    tick();
    #1;
    checks++;
    if (starve !== '0 || host_rvalid !== '0 || host_gnt !== '0) begin
      errors++;
      $display("FAIL reset_state: starve %b rvalid %b gnt %b, expected all 0", starve,
               host_rvalid, host_gnt);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (host_gnt !== 3'b001) begin
      errors++;
      $display("FAIL reset_priority: gnt %b, expected 001", host_gnt);
    end
    push_rsp(0, host_addr[31:0]);
    tick();
    host_req = '0;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [NH-1:0] exp;
    do_reset();
    for (int h = 0; h < 3; h++) host_addr[h*32 +: 32] = 32'h10 + 32'(h) * 4;
    host_req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp = NH'(1) << (i % 3);
      checks++;
      if (host_gnt !== exp || dev_req !== 2'b01) begin
        errors++;
        $display("FAIL rr_grant step %0d: gnt %b dreq %b, expected %b 01", i, host_gnt,
                 dev_req, exp);
      end
      push_rsp(i % 3, 32'h10 + 32'(i % 3) * 4);
      tick();
    end
    host_req = '0;
    tick();
    tick();
  endtask

  task automatic test_read();
    do_reset();
    host_addr[32 +: 32] = 32'h0000_0010;
    host_we = 3'b000;
    host_req = 3'b010;
    #1;
    checks++;
    if (host_gnt !== 3'b010 || dev_req !== 2'b01 || dev_addr !== 32'h10 || dev_we !== 1'b0) begin
      errors++;
      $display("FAIL read_req: gnt %b dreq %b addr %h we %b, expected 010 01 00000010 0",
               host_gnt, dev_req, dev_addr, dev_we);
    end
    push_rsp(1, 32'h0000_0010);
    tick();
    host_req = 3'b001;
    host_we = 3'b001;
    host_be[3:0] = 4'b0110;
    host_addr[31:0] = 32'h0001_0044;
    host_wdata[31:0] = 32'hCAFE_0123;
    #1;
    checks++;
    if (host_gnt !== 3'b001 || dev_req !== 2'b10 || dev_we !== 1'b1 || dev_be !== 4'b0110 ||
        dev_addr !== 32'h0001_0044 || dev_wdata !== 32'hCAFE_0123) begin
      errors++;
      $display("FAIL write_req: gnt %b dreq %b we %b be %b addr %h wdata %h", host_gnt,
               dev_req, dev_we, dev_be, dev_addr, dev_wdata);
    end
    push_rsp(0, 32'h0001_0044);
    tick();
    host_req = '0;
    host_we = '0;
    tick();
    tick();
  endtask

  task automatic test_decode_miss();
    do_reset();
    host_addr[64 +: 32] = 32'h0003_0000;
    host_req = 3'b100;
    #1;
    checks++;
    if (host_gnt !== 3'b100 || dev_req !== 2'b00) begin
      errors++;
      $display("FAIL miss_req: gnt %b dreq %b, expected 100 00", host_gnt, dev_req);
    end
    push_rsp(2, 32'h0003_0000);
    tick();
    host_req = '0;
    tick();
    tick();
  endtask

  task automatic test_alternate();
    logic [NH-1:0] exp;
    do_reset();
    host_addr[31:0] = 32'h0000_0100;
    host_addr[64 +: 32] = 32'h0001_0200;
    host_req = 3'b001;
    #1;
    checks++;
    if (host_gnt !== 3'b001) begin
      errors++;
      $display("FAIL alt_prime: gnt %b, expected 001", host_gnt);
    end
    push_rsp(0, 32'h0000_0100);
    tick();
    host_req = 3'b101;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp = (i % 2 == 0) ? 3'b100 : 3'b001;
      checks++;
      if (host_gnt !== exp || starve[1] !== 1'b0) begin
        errors++;
        $display("FAIL alt_grant step %0d: gnt %b starve %b, expected %b x0x", i, host_gnt,
                 starve, exp);
      end
      push_rsp((i % 2 == 0) ? 2 : 0, (i % 2 == 0) ? 32'h0001_0200 : 32'h0000_0100);
      tick();
    end
    host_req = '0;
    tick();
    #1;
    checks++;
    if (starve !== 3'b000) begin
      errors++;
      $display("FAIL alt_starve: starve %b, expected 000", starve);
    end
    tick();
  endtask

  task automatic test_starve();
    logic [NH-1:0] exp_gnt [3];
    logic [NH-1:0] exp_stv [3];
    logic [NH-1:0] reqs [3];
    exp_gnt = '{3'b001, 3'b010, 3'b100};
    exp_stv = '{3'b000, 3'b000, 3'b100};
    reqs = '{3'b111, 3'b111, 3'b100};
    do_reset();
    for (int h = 0; h < 3; h++) host_addr[h*32 +: 32] = 32'h20;
    for (int i = 0; i < 3; i++) begin
      host_req = reqs[i];
      #1;
      checks++;
      if (host_gnt !== exp_gnt[i] || starve !== exp_stv[i]) begin
        errors++;
        $display("FAIL starve_seq step %0d: gnt %b starve %b, expected %b %b", i, host_gnt,
                 starve, exp_gnt[i], exp_stv[i]);
      end
      push_rsp(i, 32'h20);
      tick();
    end
    host_req = '0;
    tick();
    tick();
    #1;
    checks++;
    if (starve !== 3'b100) begin
      errors++;
      $display("FAIL starve_sticky: starve %b, expected 100", starve);
    end
    rst = 1'b1;
    tick();
    #1;
    checks++;
    if (starve !== 3'b000) begin
      errors++;
      $display("FAIL starve_clear: starve %b, expected 000", starve);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    host_addr[32 +: 32] = 32'h40;
    host_addr[64 +: 32] = 32'h44;
    host_req = 3'b010;
    #1;
    checks++;
    if (host_gnt !== 3'b010) begin
      errors++;
      $display("FAIL mid_grant: gnt %b, expected 010", host_gnt);
    end
    tick();
    rst = 1'b1;
    host_req = 3'b111;
    #1;
    checks++;
    if (host_rvalid !== '0 || host_gnt !== '0) begin
      errors++;
      $display("FAIL mid_drop: rvalid %b gnt %b, expected 000 000", host_rvalid, host_gnt);
    end
    tick();
    rst = 1'b0;
    host_req = 3'b110;
    #1;
    checks++;
    if (host_rvalid !== '0 || host_gnt !== 3'b010) begin
      errors++;
      $display("FAIL mid_first: rvalid %b gnt %b, expected 000 010", host_rvalid, host_gnt);
    end
    push_rsp(1, 32'h40);
    tick();
    host_req = '0;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    host_req = '0;
    host_we = '0;
    host_be = '1;
    host_addr = '0;
    host_wdata = '0;
    dev_rdata = {32'h0BAD_F00D, 32'hDEAD_BEEF};
    dev_err = 2'b10;
    cfg_base = {32'h0001_0000, 32'h0000_0000};
    cfg_mask = {32'hFFFF_0000, 32'hFFFF_0000};
    test_reset();
    test_round_robin();
    test_read();
    test_decode_miss();
    test_alternate();
    test_starve();
    test_reset_mid();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
